// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: latches an 8-bit value and shows it as two hex digits,
// time-multiplexed onto one shared active-high 7-segment bus.
// Features: refresh prescaler, a blanking window at the start of each slot
// (anti-ghosting), leading-zero suppression of the high digit, and blink.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - enable; low freezes all counters and blanks the outputs
//   data_in     - value to display, captured when load is high
//   load        - capture data_in/dp_in on this clock edge (needs ena)
//   dp_in       - decimal-point request, captured with load
//   blank_lz    - hide the high digit when the high nibble is zero
//   blink       - blink the whole display
//   seg_out     - segments a..g on bits 0..6 (registered)
//   dp_out      - decimal point, shown on the low digit only (registered)
//   digit_en    - one-hot digit enable, bit0 = low nibble (registered)
module seg7_mux_driver #(
  parameter logic [15:0] REFRESH_COUNT = 16'd1000,
  parameter logic [15:0] BLANK_CYCLES  = 16'd2,
  parameter logic [7:0]  BLINK_SCANS   = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       dp_in,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [1:0] digit_en
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BLINK_W = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIG_W   = 2;

  // Hex digit to segment pattern (bit0 = a ... bit6 = g).
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [DATA_W-1:0]  data_q, data_d;
  logic               dp_q, dp_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic               digit_sel_q, digit_sel_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_out_q, dp_out_d;
  logic [DIG_W-1:0]   digit_en_q, digit_en_d;

  logic               tick_c;
  logic               show_c;
  logic [3:0]         nib_c;

  // Next-state: data latch, scan counters and registered display outputs.
  always_comb begin
    data_d        = data_q;
    dp_d          = dp_q;
    presc_d       = presc_q;
    digit_sel_d   = digit_sel_q;
    blank_cnt_d   = blank_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    tick_c        = 1'b0;

    if (ena) begin
      if (load) begin
        data_d = data_in;
        dp_d   = dp_in;
      end
      tick_c = (presc_q == REFRESH_COUNT - 16'd1);
      if (tick_c) begin
        presc_d     = '0;
        digit_sel_d = ~digit_sel_q;
        blank_cnt_d = '0;
        if (blink_cnt_q == BLINK_SCANS - 8'd1) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end else begin
        presc_d = presc_q + CNT_W'(1);
        // Saturates at BLANK_CYCLES so the window ends and stays open.
        if (blank_cnt_q < BLANK_CYCLES) begin
          blank_cnt_d = blank_cnt_q + CNT_W'(1);
        end
      end
    end

    // Outputs follow current state with one register of latency.
    nib_c  = digit_sel_q ? data_q[7:4] : data_q[3:0];
    show_c = ena
           && (blank_cnt_q >= BLANK_CYCLES)
           && !(blink && blink_phase_q)
           && !(blank_lz && digit_sel_q && (data_q[7:4] == 4'h0));

    digit_en_d = show_c ? (digit_sel_q ? 2'b10 : 2'b01) : 2'b00;
    seg_d      = show_c ? hex7(nib_c) : '0;
    dp_out_d   = show_c && !digit_sel_q && dp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q        <= '0;
      dp_q          <= 1'b0;
      presc_q       <= '0;
      digit_sel_q   <= 1'b0;
      blank_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= '0;
      dp_out_q      <= 1'b0;
      digit_en_q    <= '0;
    end else begin
      data_q        <= data_d;
      dp_q          <= dp_d;
      presc_q       <= presc_d;
      digit_sel_q   <= digit_sel_d;
      blank_cnt_q   <= blank_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      digit_en_q    <= digit_en_d;
    end
  end

  assign seg_out  = seg_q;
  assign dp_out   = dp_out_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver with a short refresh (4 clocks), a
// 1-clock blank window and 2 slots per blink phase.
module tb_seg7_mux_driver;

  localparam int RC = 4;
  localparam int BC = 1;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       load;
  logic       dp_in;
  logic       blank_lz;
  logic       blink;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [1:0] digit_en;

  seg7_mux_driver #(
    .REFRESH_COUNT(16'd4),
    .BLANK_CYCLES (16'd1),
    .BLINK_SCANS  (8'd2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .data_in (data_in),
    .load    (load),
    .dp_in   (dp_in),
    .blank_lz(blank_lz),
    .blink   (blink),
    .seg_out (seg_out),
    .dp_out  (dp_out),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [7:0] m_data;
  logic       m_dp;
  int         m_presc;
  logic       m_sel;
  int         m_blank;
  int         m_bcnt;
  logic       m_phase;

  // Scoreboard of expected {seg, dp, digit_en}
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_dp    = 1'b0;
    m_presc = 0;
    m_sel   = 1'b0;
    m_blank = 0;
    m_bcnt  = 0;
    m_phase = 1'b0;
    exp_q.delete();
  endtask

  // Predict the output produced by the coming edge, then advance the model.
  task automatic model_step();
    logic [3:0] nib;
    logic       on;
    logic [1:0] en;
    logic [6:0] sg;
    logic       dp;
    nib = m_sel ? m_data[7:4] : m_data[3:0];
    on  = ena && (m_blank >= BC) && !(blink && m_phase)
          && !(blank_lz && m_sel && (m_data[7:4] == 4'h0));
    en  = on ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
    sg  = on ? hex_tab[nib] : 7'h00;
    dp  = (en == 2'b01) ? m_dp : 1'b0;
    exp_q.push_back({sg, dp, en});
    if (ena) begin
      if (load) begin
        m_data = data_in;
        m_dp   = dp_in;
      end
      if (m_presc == RC - 1) begin
        m_presc = 0;
        m_sel   = ~m_sel;
        m_blank = 0;
        if (m_bcnt == BS - 1) begin
          m_bcnt  = 0;
          m_phase = ~m_phase;
        end else begin
          m_bcnt++;
        end
      end else begin
        m_presc++;
        if (m_blank < BC) m_blank++;
      end
    end
  endtask

  // One clock: predict, clock, compare against the scoreboard.
  task automatic cyc();
    logic [9:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      fail_now("sb_empty");
    end else begin
      e = exp_q.pop_front();
      check("sb_seg", 8'(seg_out), 8'(e[9:3]));
      check("sb_dp", 8'(dp_out), 8'(e[2]));
      check("sb_en", 8'(digit_en), 8'(e[1:0]));
    end
    check("never_11", 8'(digit_en == 2'b11), 8'h00);
  endtask

  task automatic wait_en(input logic [1:0] want, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (digit_en == want) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now(tag);
  endtask

  task automatic count_run(input logic [1:0] val, output int len);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (digit_en == val) len++;
      else break;
    end
  endtask

  task automatic load_val(input logic [7:0] v, input logic d);
    data_in = v;
    dp_in   = d;
    load    = 1'b1;
    cyc();
    load    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int cnt;
    logic found;

    rst_n = 1'b0; ena = 1'b1; data_in = 8'h00; load = 1'b0;
    dp_in = 1'b0; blank_lz = 1'b0; blink = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_seg", 8'(seg_out), 8'h00);
    check("rst_dp", 8'(dp_out), 8'h00);
    check("rst_en", 8'(digit_en), 8'h00);
    rst_n = 1'b1;

    // Decode and scan of 0xA5 with decimal point
    load_val(8'hA5, 1'b1);
    wait_en(2'b01, "a5_wait_d0");
    check("a5_d0_seg", 8'(seg_out), 8'h6D);
    check("a5_d0_dp", 8'(dp_out), 8'h01);
    wait_en(2'b10, "a5_wait_d1");
    check("a5_d1_seg", 8'(seg_out), 8'h77);
    check("a5_d1_dp", 8'(dp_out), 8'h00);
    count_run(2'b10, len);
    check("a5_on_len", 8'(len), 8'd3);
    check("a5_blank_en", 8'(digit_en), 8'h00);
    count_run(2'b00, len);
    check("a5_blank_len", 8'(len), 8'd1);
    check("a5_back_d0", 8'(digit_en), 8'h01);

    // Asynchronous reset mid-scan while outputs are active
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 8'(seg_out), 8'h00);
    check("arst_dp", 8'(dp_out), 8'h00);
    check("arst_en", 8'(digit_en), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (digit_en != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("arst_resume");
    check("arst_first_d0", 8'(digit_en), 8'h01);

    // Full value sweep, two slots per value
    for (int v = 0; v < 256; v++) begin
      load_val(8'(v), v[0]);
      repeat (7) cyc();
    end

    // Leading-zero suppression
    blank_lz = 1'b1;
    load_val(8'h07, 1'b0);
    cnt = 0;
    repeat (12) begin
      cyc();
      if (digit_en == 2'b10) cnt++;
    end
    check("lz_hidden", 8'(cnt), 8'd0);
    load_val(8'h00, 1'b0);
    wait_en(2'b01, "lz00_wait_d0");
    check("lz00_d0_seg", 8'(seg_out), 8'h3F);
    load_val(8'h07, 1'b0);
    blank_lz = 1'b0;
    wait_en(2'b10, "lz_off_wait_d1");
    check("lz_off_seg", 8'(seg_out), 8'h3F);

    // Blink: 6 lit clocks per 16 with blink, 12 without
    load_val(8'h5A, 1'b0);
    blink = 1'b1;
    repeat (16) cyc();
    cnt = 0;
    repeat (16) begin
      cyc();
      if (digit_en != 2'b00) cnt++;
    end
    check("blink_on_cnt", 8'(cnt), 8'd6);
    blink = 1'b0;
    repeat (16) cyc();
    cnt = 0;
    repeat (16) begin
      cyc();
      if (digit_en != 2'b00) cnt++;
    end
    check("noblink_cnt", 8'(cnt), 8'd12);

    // ena low: outputs off, load ignored, scan resumes from held state
    load_val(8'h07, 1'b0);
    ena = 1'b0;
    data_in = 8'hFF;
    load = 1'b1;
    repeat (10) begin
      cyc();
      check("ena0_en", 8'(digit_en), 8'h00);
    end
    load = 1'b0;
    ena = 1'b1;
    wait_en(2'b10, "ena1_wait_d1");
    check("ena1_d1_seg", 8'(seg_out), 8'h3F);
    wait_en(2'b01, "ena1_wait_d0");
    check("ena1_d0_seg", 8'(seg_out), 8'h07);

    // Load coinciding with a tick into the digit-1 slot
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_presc == RC - 1 && m_sel == 1'b0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    if (!found) fail_now("tick_align");
    load_val(8'h3C, 1'b0);
    cyc();
    check("tick_blank_en", 8'(digit_en), 8'h00);
    wait_en(2'b10, "tick_wait_d1");
    check("tick_d1_seg", 8'(seg_out), 8'h4F);
    wait_en(2'b01, "tick_wait_d0");
    check("tick_d0_seg", 8'(seg_out), 8'h39);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
